// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush arbitration for the if_id -> id -> ex core.
// Also owns the external bus grant, its watchdog and a stall counter.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_ex_i,
  input  logic        hold_bus_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic [4:0]  id_reg1_raddr_i,
  input  logic [4:0]  id_reg2_raddr_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        flush_o,
  output logic [2:0]  hold_flag_o,
  output logic        bus_grant_o,
  output logic        timeout_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TMO        = 16'(HOLD_TIMEOUT);
  localparam bit          TMO_EN     = (HOLD_TIMEOUT != 0);
  localparam bit          MULTI      = (FLUSH_CYCLES > 1);

  state_e      state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        grant_q, grant_d;
  logic [15:0] bus_cnt_q, bus_cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] stall_q, stall_d;

  logic        lu;
  logic        flush;
  logic        grant;
  logic [2:0]  hold;

  always_comb begin
    lu = ex_load_i
       & (ex_reg_waddr_i != 5'd0)
       & ((id_reg1_raddr_i == ex_reg_waddr_i)
        | (id_reg2_raddr_i == ex_reg_waddr_i));
    flush = jump_flag_i | (state_q == FLUSH);
    grant = grant_q & hold_bus_i;
    hold  = 3'd0;
    // rst gates the drain hold so a core in reset never freezes the PC
    if (grant | hold_ex_i) begin
      hold = 3'd3;
    end else if (hold_bus_i & rst) begin
      hold = 3'd1;
    end else if (lu & ~flush) begin
      hold = 3'd2;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (jump_flag_i) begin
      flush_cnt_d = FLUSH_LOAD;
      state_d     = MULTI ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      if (flush_cnt_q != 3'd0) begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
      if (flush_cnt_q <= 3'd1) begin
        state_d = RUN;
      end
    end
  end

  always_comb begin
    grant_d   = hold_bus_i & ~jump_flag_i & ~hold_ex_i;
    bus_cnt_d = 16'd0;
    if (hold_bus_i) begin
      bus_cnt_d = (bus_cnt_q == 16'hFFFF) ? bus_cnt_q
                                          : bus_cnt_q + 16'd1;
    end
    timeout_d = timeout_q
              | (TMO_EN && hold_bus_i && (bus_cnt_d == TMO));
    stall_d = stall_q;
    if ((hold != 3'd0) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      grant_q     <= 1'b0;
      bus_cnt_q   <= 16'd0;
      timeout_q   <= 1'b0;
      stall_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      grant_q     <= grant_d;
      bus_cnt_q   <= bus_cnt_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
    end
  end

  assign jump_flag_o = jump_flag_i;
  assign jump_addr_o = jump_addr_i;
  assign flush_o     = flush;
  assign hold_flag_o = hold;
  assign bus_grant_o = grant;
  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a 2-cycle/T=8 instance and a
// 4-cycle/watchdog-off instance share the same directed stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jf = 1'b0;
  logic [31:0] ja = 32'd0;
  logic        hex = 1'b0;
  logic        hbus = 1'b0;
  logic        ld = 1'b0;
  logic [4:0]  wa = 5'd0;
  logic [4:0]  r1 = 5'd0;
  logic [4:0]  r2 = 5'd0;

  logic        a_jf, a_fl, a_gr, a_to;
  logic [31:0] a_ja, a_st;
  logic [2:0]  a_hd;
  logic        b_jf, b_fl, b_gr, b_to;
  logic [31:0] b_ja, b_st;
  logic [2:0]  b_hd;

  pipe_ctrl #(.FLUSH_CYCLES(2), .HOLD_TIMEOUT(8)) u_a (
    .clk(clk), .rst(rst),
    .jump_flag_i(jf), .jump_addr_i(ja),
    .hold_ex_i(hex), .hold_bus_i(hbus),
    .ex_load_i(ld), .ex_reg_waddr_i(wa),
    .id_reg1_raddr_i(r1), .id_reg2_raddr_i(r2),
    .jump_flag_o(a_jf), .jump_addr_o(a_ja),
    .flush_o(a_fl), .hold_flag_o(a_hd),
    .bus_grant_o(a_gr), .timeout_o(a_to),
    .stall_cnt_o(a_st)
  );

  pipe_ctrl #(.FLUSH_CYCLES(4), .HOLD_TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst),
    .jump_flag_i(jf), .jump_addr_i(ja),
    .hold_ex_i(hex), .hold_bus_i(hbus),
    .ex_load_i(ld), .ex_reg_waddr_i(wa),
    .id_reg1_raddr_i(r1), .id_reg2_raddr_i(r2),
    .jump_flag_o(b_jf), .jump_addr_o(b_ja),
    .flush_o(b_fl), .hold_flag_o(b_hd),
    .bus_grant_o(b_gr), .timeout_o(b_to),
    .stall_cnt_o(b_st)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    logic        jf;
    logic [31:0] ja;
    logic        fa;
    logic [2:0]  ha;
    logic        ga;
    logic        ta;
    logic [31:0] sa;
    logic        fb;
    logic [2:0]  hb;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   row_n  = 0;

  task automatic chk(input string n, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", n, row, act, exp);
    end
  endtask

  // monitor: compare whatever the driver queued for this cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("jump_flag", e.row, 32'(a_jf), 32'(e.jf));
      chk("jump_addr", e.row, a_ja, e.ja);
      chk("a_flush", e.row, 32'(a_fl), 32'(e.fa));
      chk("a_hold", e.row, 32'(a_hd), 32'(e.ha));
      chk("a_grant", e.row, 32'(a_gr), 32'(e.ga));
      chk("a_timeout", e.row, 32'(a_to), 32'(e.ta));
      chk("a_stall", e.row, a_st, e.sa);
      chk("b_flush", e.row, 32'(b_fl), 32'(e.fb));
      chk("b_hold", e.row, 32'(b_hd), 32'(e.hb));
      chk("b_timeout", e.row, 32'(b_to), 32'd0);
    end
  end

  task automatic step(
    input logic r, input logic j, input logic [31:0] a,
    input logic x, input logic b, input logic l,
    input logic [4:0] w, input logic [4:0] s1, input logic [4:0] s2,
    input logic efa, input logic [2:0] eha, input logic ega,
    input logic eta, input logic [31:0] esa,
    input logic efb, input logic [2:0] ehb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; jf = j; ja = a; hex = x; hbus = b;
    ld = l; wa = w; r1 = s1; r2 = s2;
    e.row = row_n; e.jf = j; e.ja = a;
    e.fa = efa; e.ha = eha; e.ga = ega; e.ta = eta; e.sa = esa;
    e.fb = efb; e.hb = ehb;
    sb.push_back(e);
    row_n++;
  endtask

  initial begin
    // r  jf ja        hx hb ld wa r1 r2 | fa ha ga ta sa | fb hb
    step(0,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,0,   0,0);
    step(0,0,32'h0,    0,1,0,0,0,0,  0,0,0,0,0,   0,0);
    step(0,0,32'h0,    0,0,1,5,0,5,  0,2,0,0,0,   0,2);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,0,   0,0);
    // single jump
    step(1,1,32'h100,  0,0,0,0,0,0,  1,0,0,0,0,   1,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  1,0,0,0,0,   1,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,0,   1,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,0,   1,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,0,   0,0);
    // load-use
    step(1,0,32'h0,    0,0,1,5,0,5,  0,2,0,0,0,   0,2);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,1,   0,0);
    step(1,0,32'h0,    0,0,1,0,0,0,  0,0,0,0,1,   0,0);
    step(1,0,32'h0,    0,0,1,7,7,3,  0,2,0,0,1,   0,2);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,2,   0,0);
    // bus request for 4 cycles
    step(1,0,32'h0,    0,1,0,0,0,0,  0,1,0,0,2,   0,1);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,0,3,   0,3);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,0,4,   0,3);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,0,5,   0,3);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,6,   0,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,6,   0,0);
    // ex busy blocks the grant
    step(1,0,32'h0,    1,1,0,0,0,0,  0,3,0,0,6,   0,3);
    step(1,0,32'h0,    1,1,0,0,0,0,  0,3,0,0,7,   0,3);
    step(1,0,32'h0,    1,1,0,0,0,0,  0,3,0,0,8,   0,3);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,1,0,0,9,   0,1);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,0,10,  0,3);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,11,  0,0);
    // 10-cycle hold, watchdog at 8
    step(1,0,32'h0,    0,1,0,0,0,0,  0,1,0,0,11,  0,1);
    for (int k = 1; k < 8; k++) begin
      step(1,0,32'h0,  0,1,0,0,0,0,  0,3,1,0,32'(11+k), 0,3);
    end
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,1,19,  0,3);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,1,20,  0,3);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,1,21,  0,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,1,21,  0,0);
    // reset in the middle of a grant
    step(1,0,32'h0,    0,1,0,0,0,0,  0,1,0,1,21,  0,1);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,1,22,  0,3);
    step(0,0,32'h0,    0,1,0,0,0,0,  0,0,0,0,0,   0,0);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,1,0,0,0,   0,1);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,1,   0,0);
    // jump together with a bus request
    step(1,1,32'h200,  0,1,0,0,0,0,  1,1,0,0,1,   1,1);
    step(1,0,32'h0,    0,1,0,0,0,0,  1,1,0,0,2,   1,1);
    step(1,0,32'h0,    0,1,0,0,0,0,  0,3,1,0,3,   1,3);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,4,   1,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,4,   0,0);
    // jump restarting the window, load-use inside it
    step(1,1,32'h300,  0,0,0,0,0,0,  1,0,0,0,4,   1,0);
    step(1,1,32'h340,  0,0,0,0,0,0,  1,0,0,0,4,   1,0);
    step(1,0,32'h0,    0,0,1,5,5,0,  1,0,0,0,4,   1,0);
    step(1,0,32'h0,    0,0,1,5,5,0,  0,2,0,0,4,   1,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,5,   1,0);
    step(1,0,32'h0,    0,0,0,0,0,0,  0,0,0,0,5,   0,0);
    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 5) begin
        @(posedge clk);
        budget++;
      end
      checks++;
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
